ring_injector: RTL and testbench
================================

// Module: ring_injector
// PURPOSE
//  Closes the engine ring: takes tokens leaving the last engine_and_station channel and feeds the
//  first station's input. Merges new thread tokens from the control unit into that stream.
//  Registered output with valid/ready handshake. Starvation-bounded arbitration between ring and
//  injection traffic. Reports ring quiescence so the controller knows when to advance the character.
// PARAMETERS
//  PC_WIDTH            8  PC bits; token width is PC_WIDTH+1 (MSB = even/odd character tag)
//  STARVE_LIMIT        4  consecutive lost arbitration cycles before injection is forced (>=1)
//  QUIET_CYCLES       16  consecutive idle cycles before ring_quiet asserts (>=1)
//  STARVE_COUNT_WIDTH  3  width of starvation counter; must hold STARVE_LIMIT
//  QUIET_COUNT_WIDTH   5  width of quiet counter; must hold QUIET_CYCLES
// PORTS
//  clk            in   1            clock, all logic rising-edge
//  rst            in   1            asynchronous, active-low reset
//  ring_in_valid  in   1            token from last station channel valid
//  ring_in_ready  out  1            ring token accepted this cycle
//  ring_in_data   in   PC_WIDTH+1   {tag, pc} from ring
//  inj_valid      in   1            control unit offers new thread token
//  inj_ready      out  1            injected token accepted this cycle
//  inj_data       in   PC_WIDTH+1   {tag, pc} to inject
//  ring_out_valid out  1            token to first station valid (registered)
//  ring_out_ready in   1            first station accepts token
//  ring_out_data  out  PC_WIDTH+1   {tag, pc} to first station (registered)
//  ring_quiet     out  1            no traffic for QUIET_CYCLES consecutive cycles
// BEHAVIOUR
//  Reset (rst=0, async): ring_out_valid=0, ring_out_data=0, starve_cnt=0, quiet_cnt=0, ring_quiet=0.
//  load = !ring_out_valid || ring_out_ready (output register free or draining this cycle).
//  Arbitration, evaluated only when load=1:
//   - force = inj_valid && (starve_cnt == STARVE_LIMIT).
//   - force=1: inject wins; inj_ready=1, ring_in_ready=0.
//   - else ring_in_valid=1: ring wins; ring_in_ready=1, inj_ready=0.
//   - else inj_valid=1: inject wins; inj_ready=1.
//   - load=0: both readies 0; output register holds data stable (no change while valid && !ready).
//  Readies are combinational from load/valids; no valid depends on a ready (no comb. loop).
//  Winner's data loads ring_out_data next edge, ring_out_valid<=1. No winner and load: valid<=0.
//  Latency: accepted token appears on ring_out one cycle later; full throughput 1 token/cycle.
//  Token content passed unmodified; no reordering within either source.
//  starve_cnt: cleared when inj fires or inj_valid=0; +1 when inj_valid && !inj_ready; saturates
//   at STARVE_LIMIT. Guarantees an injection within STARVE_LIMIT+1 load cycles.
//  quiet_cnt: cleared when ring_in_valid || inj_valid || ring_out_valid; else +1, saturating at
//   QUIET_CYCLES. ring_quiet = (quiet_cnt == QUIET_CYCLES), registered.
//   Any new activity drops ring_quiet the next cycle.
//  Simultaneous ring_in_valid and inj_valid without force: ring wins (in-flight threads drain first).
//  Back-pressure: ring_out_ready=0 with ring_out_valid=1 stalls both sources; counters still run.
//   starve_cnt increments only on load cycles where inj loses.
//  Reset mid-operation drops any held token; upstream must re-inject after reset.
// CONFIGURATION
//  RING_INJECTOR_STATS_EN defined: adds outputs stat_injected and stat_forwarded (32 bits each).
//   They count inj and ring handshakes. Both clear on reset, wrap modulo 2^32, and read 0 after reset.
//  Not defined: ports and counters absent; functional behaviour otherwise identical.
// TESTING
//  Reset then idle: all outputs 0; after QUIET_CYCLES=16 idle cycles -> ring_quiet=1 on cycle 17.
//  Inject {1,8'h05} with ring idle, ring_out_ready=1 -> inj_ready=1, next cycle ring_out_data=9'h105.
//  ring_in_valid=1 continuously plus inj_valid=1, STARVE_LIMIT=4 -> injection accepted 5th cycle.
//   Ring stalled that one cycle only.
//  Hold ring_out_ready=0 with token 9'h0AA loaded for 10 cycles -> data/valid stable, both readies 0.
//  Mid-stream rst=0 pulse with ring_out_valid=1 -> ring_out_valid=0 immediately (async).
//   Counters are 0 after release.
//  STATS_EN: 3 injections and 7 ring tokens -> stat_injected=3, stat_forwarded=7.

Source files
------------

// File: rtl/ring_injector.sv
// ring_injector: closes the engine ring by merging control-unit thread tokens
// into the stream leaving the last station and feeding the first station.
// Registered valid/ready output stage, starvation-bounded arbitration between
// ring and injection traffic, and a registered ring-quiescence flag.
// Optional build macro: RING_INJECTOR_STATS_EN adds stat_injected/stat_forwarded.
module ring_injector #(
  parameter int PC_WIDTH           = 8,
  parameter int STARVE_LIMIT       = 4,
  parameter int QUIET_CYCLES       = 16,
  parameter int STARVE_COUNT_WIDTH = 3,
  parameter int QUIET_COUNT_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ring_in_valid,
  output logic                ring_in_ready,
  input  logic [PC_WIDTH:0]   ring_in_data,
  input  logic                inj_valid,
  output logic                inj_ready,
  input  logic [PC_WIDTH:0]   inj_data,
  output logic                ring_out_valid,
  input  logic                ring_out_ready,
  output logic [PC_WIDTH:0]   ring_out_data,
  output logic                ring_quiet
`ifdef RING_INJECTOR_STATS_EN
  ,
  output logic [31:0]         stat_injected,
  output logic [31:0]         stat_forwarded
`endif
);

  localparam logic [STARVE_COUNT_WIDTH-1:0] STARVE_MAX  = STARVE_COUNT_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_COUNT_WIDTH-1:0] STARVE_ZERO = {STARVE_COUNT_WIDTH{1'b0}};
  localparam logic [STARVE_COUNT_WIDTH-1:0] STARVE_ONE  = STARVE_COUNT_WIDTH'(1);
  localparam logic [QUIET_COUNT_WIDTH-1:0]  QUIET_MAX   = QUIET_COUNT_WIDTH'(QUIET_CYCLES);
  localparam logic [QUIET_COUNT_WIDTH-1:0]  QUIET_ZERO  = {QUIET_COUNT_WIDTH{1'b0}};
  localparam logic [QUIET_COUNT_WIDTH-1:0]  QUIET_ONE   = QUIET_COUNT_WIDTH'(1);

  logic                          load;
  logic                          force_inj;
  logic                          activity;
  logic [STARVE_COUNT_WIDTH-1:0] starve_cnt;
  logic [STARVE_COUNT_WIDTH-1:0] starve_nxt;
  logic [QUIET_COUNT_WIDTH-1:0]  quiet_cnt;
  logic [QUIET_COUNT_WIDTH-1:0]  quiet_nxt;
  logic                          quiet_flag_nxt;

  // Arbitration: a starved injector overrides the ring, otherwise ring traffic drains first.
  always_comb begin
    load          = 1'b0;
    force_inj     = 1'b0;
    ring_in_ready = 1'b0;
    inj_ready     = 1'b0;
    load          = !ring_out_valid || ring_out_ready;
    force_inj     = inj_valid && (starve_cnt == STARVE_MAX);
    if (load) begin
      if (force_inj) begin
        inj_ready = 1'b1;
      end else if (ring_in_valid) begin
        ring_in_ready = 1'b1;
      end else if (inj_valid) begin
        inj_ready = 1'b1;
      end else begin
        ring_in_ready = 1'b0;
        inj_ready     = 1'b0;
      end
    end else begin
      ring_in_ready = 1'b0;
      inj_ready     = 1'b0;
    end
  end

  // Next values of the starvation and quiescence counters.
  always_comb begin
    starve_nxt     = starve_cnt;
    quiet_nxt      = quiet_cnt;
    quiet_flag_nxt = 1'b0;
    activity       = ring_in_valid || inj_valid || ring_out_valid;
    // Starvation only advances on load cycles the injector loses; stalls freeze it.
    if (!inj_valid || inj_ready) begin
      starve_nxt = STARVE_ZERO;
    end else if (load && (starve_cnt != STARVE_MAX)) begin
      starve_nxt = starve_cnt + STARVE_ONE;
    end else begin
      starve_nxt = starve_cnt;
    end
    // Any activity restarts the idle count and drops the quiet flag on the next edge.
    if (activity) begin
      quiet_nxt      = QUIET_ZERO;
      quiet_flag_nxt = 1'b0;
    end else if (quiet_cnt != QUIET_MAX) begin
      quiet_nxt      = quiet_cnt + QUIET_ONE;
      quiet_flag_nxt = 1'b0;
    end else begin
      quiet_nxt      = quiet_cnt;
      quiet_flag_nxt = 1'b1;
    end
  end

  // Output register: load the arbitration winner, hold stable while back-pressured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ring_out_valid <= 1'b0;
      ring_out_data  <= {(PC_WIDTH+1){1'b0}};
    end else if (load) begin
      if (inj_ready) begin
        ring_out_valid <= 1'b1;
        ring_out_data  <= inj_data;
      end else if (ring_in_ready) begin
        ring_out_valid <= 1'b1;
        ring_out_data  <= ring_in_data;
      end else begin
        ring_out_valid <= 1'b0;
      end
    end else begin
      ring_out_valid <= ring_out_valid;
      ring_out_data  <= ring_out_data;
    end
  end

  // Counter and quiet-flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= STARVE_ZERO;
      quiet_cnt  <= QUIET_ZERO;
      ring_quiet <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      quiet_cnt  <= quiet_nxt;
      ring_quiet <= quiet_flag_nxt;
    end
  end

`ifdef RING_INJECTOR_STATS_EN
  // Handshake statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_injected  <= 32'd0;
      stat_forwarded <= 32'd0;
    end else begin
      stat_injected  <= stat_injected  + (inj_valid && inj_ready ? 32'd1 : 32'd0);
      stat_forwarded <= stat_forwarded + (ring_in_valid && ring_in_ready ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_ring_injector.sv
// Self-checking bench for ring_injector: a cycle-level reference model plus
// directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ring_injector;

  localparam int STARVE = 4;
  localparam int QUIET  = 16;

  logic       clk;
  logic       rst;
  logic       ring_in_valid;
  logic       ring_in_ready;
  logic [8:0] ring_in_data;
  logic       inj_valid;
  logic       inj_ready;
  logic [8:0] inj_data;
  logic       ring_out_valid;
  logic       ring_out_ready;
  logic [8:0] ring_out_data;
  logic       ring_quiet;
`ifdef RING_INJECTOR_STATS_EN
  logic [31:0] stat_injected;
  logic [31:0] stat_forwarded;
`endif

  int checks = 0;
  int errors = 0;

  ring_injector dut (
    .clk(clk), .rst(rst),
    .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready), .ring_in_data(ring_in_data),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_data(inj_data),
    .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready), .ring_out_data(ring_out_data),
    .ring_quiet(ring_quiet)
`ifdef RING_INJECTOR_STATS_EN
    , .stat_injected(stat_injected), .stat_forwarded(stat_forwarded)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_valid;
  logic [8:0] m_data;
  int         m_lost;      // consecutive load cycles the pending injection lost
  int         m_idle;      // consecutive idle cycles, capped
  logic       m_quiet;
  int         m_inj_cnt;
  int         m_ring_cnt;

  logic e_free, e_inj, e_ring, e_busy;
  assign e_free = !m_valid || ring_out_ready;
  assign e_inj  = e_free && inj_valid && (m_lost >= STARVE || !ring_in_valid);
  assign e_ring = e_free && ring_in_valid && !(inj_valid && m_lost >= STARVE);
  assign e_busy = ring_in_valid || inj_valid || m_valid;

  // Model state update, mirroring the observable token flow.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_data <= 9'h000; m_lost <= 0; m_idle <= 0; m_quiet <= 1'b0;
      m_inj_cnt <= 0; m_ring_cnt <= 0;
    end else begin
      if (e_inj) begin
        m_valid <= 1'b1; m_data <= inj_data; m_inj_cnt <= m_inj_cnt + 1;
      end else if (e_ring) begin
        m_valid <= 1'b1; m_data <= ring_in_data; m_ring_cnt <= m_ring_cnt + 1;
      end else if (e_free) begin
        m_valid <= 1'b0;
      end
      if (!inj_valid || e_inj) m_lost <= 0;
      else if (e_free) m_lost <= (m_lost < STARVE) ? m_lost + 1 : m_lost;
      m_idle  <= e_busy ? 0 : ((m_idle < QUIET) ? m_idle + 1 : m_idle);
      m_quiet <= !e_busy && (m_idle == QUIET);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("ring_out_valid", 32'(ring_out_valid), 32'(m_valid));
    chk("ring_out_data",  32'(ring_out_data),  32'(m_data));
    chk("ring_quiet",     32'(ring_quiet),     32'(m_quiet));
    chk("ring_in_ready",  32'(ring_in_ready),  32'(e_ring));
    chk("inj_ready",      32'(inj_ready),      32'(e_inj));
`ifdef RING_INJECTOR_STATS_EN
    chk("stat_injected",  stat_injected,  32'(m_inj_cnt));
    chk("stat_forwarded", stat_forwarded, 32'(m_ring_cnt));
`endif
  end

  task automatic drive(input logic rv, input logic [8:0] rd, input logic iv,
                       input logic [8:0] id, input logic ordy);
    @(posedge clk);
    #1;
    ring_in_valid  = rv;
    ring_in_data   = rd;
    inj_valid      = iv;
    inj_data       = id;
    ring_out_ready = ordy;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    ring_in_valid = 1'b0; ring_in_data = 9'h000;
    inj_valid = 1'b0; inj_data = 9'h000; ring_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_valid", 32'(ring_out_valid), 32'd0);
    chk("reset_data", 32'(ring_out_data), 32'd0);
    chk("reset_quiet", 32'(ring_quiet), 32'd0);
    rst = 1'b1;

    // Idle: quiet flag rises on the 17th edge after release, not the 16th.
    repeat (16) @(posedge clk);
    #2 chk("quiet_edge16", 32'(ring_quiet), 32'd0);
    @(posedge clk);
    #2 chk("quiet_edge17", 32'(ring_quiet), 32'd1);

    // Single injection with the ring idle.
    drive(1'b0, 9'h000, 1'b1, 9'h105, 1'b1);
    #1 chk("inj_ready_idle", 32'(inj_ready), 32'd1);
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    #1 chk("inj_out_valid", 32'(ring_out_valid), 32'd1);
    chk("inj_out_data", 32'(ring_out_data), 32'h105);
    chk("quiet_dropped", 32'(ring_quiet), 32'd0);

    // Continuous ring traffic plus a waiting injection: injection wins on cycle 5 only.
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 9'(9'h010 + i), 1'b1, 9'h033, 1'b1);
      #1 chk("starve_inj_ready", 32'(inj_ready), (i == 5) ? 32'd1 : 32'd0);
      chk("starve_ring_ready", 32'(ring_in_ready), (i == 5) ? 32'd0 : 32'd1);
    end

    // Back-pressure: load 9'h0AA then stall for 10 cycles.
    drive(1'b1, 9'h0AA, 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 9'h0BB, 1'b1, 9'h144, 1'b0);
      #1 chk("stall_data", 32'(ring_out_data), 32'h0AA);
      chk("stall_valid", 32'(ring_out_valid), 32'd1);
      chk("stall_ring_ready", 32'(ring_in_ready), 32'd0);
      chk("stall_inj_ready", 32'(inj_ready), 32'd0);
    end
    drive(1'b1, 9'h0BB, 1'b1, 9'h144, 1'b1);
    #1 chk("unstall_ring_wins", 32'(ring_in_ready), 32'd1);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 48; i++) begin
      drive(1'(i % 2) ^ 1'((i / 4) % 2), 9'(i * 7), (i % 3) != 0, 9'(9'h100 + i), (i % 5) != 1);
    end

    // Asynchronous reset while a token is held.
    drive(1'b1, 9'h0C3, 1'b0, 9'h000, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_rst_valid", 32'(ring_out_valid), 32'd0);
    chk("async_rst_data", 32'(ring_out_data), 32'd0);
    #2 rst = 1'b1;

    // Seven ring tokens then three injections.
    for (int i = 0; i < 7; i++) drive(1'b1, 9'(9'h020 + i), 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 9'h000, 1'b1, 9'(9'h1A0 + i), 1'b1);
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    #1 chk("last_inj_data", 32'(ring_out_data), 32'h1A2);
    drive(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
`ifdef RING_INJECTOR_STATS_EN
    #1 chk("stat_injected_3", stat_injected, 32'd3);
    chk("stat_forwarded_7", stat_forwarded, 32'd7);
`endif
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
